// File: rtl/ars_proj2aff_if.sv
// Handshake and operand/result bundle for the GF(2^233) projective-to-affine converter.
interface ars_proj2aff_if #(
    parameter int M = 233
);
  logic         start_i;
  logic [M-1:0] x_i;
  logic [M-1:0] z_i;
  logic         busy_o;
  logic         done_o;
  logic [M-1:0] x_out_o;
  logic         inf_o;

  modport master (
    output start_i, x_i, z_i,
    input  busy_o, done_o, x_out_o, inf_o
  );

  modport slave (
    input  start_i, x_i, z_i,
    output busy_o, done_o, x_out_o, inf_o
  );
endinterface

// File: rtl/ars_proj2aff.sv
// Affine x = X * Z^-1 over GF(2^233), f(t)=t^233+t^74+1, via Itoh-Tsujii inversion.
// Optional macro ARS_P2A_ZCHK_EN: detect Z==0 at accept, short-circuit to DONE and flag inf.
module ars_proj2aff #(
    parameter int M = 233,
    parameter int K = 74
) (
    input  logic                 clk,
    input  logic                 rst,
    ars_proj2aff_if.slave        p2a
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQR  = 3'd1,
    S_MUL  = 3'd2,
    S_FSQ  = 3'd3,
    S_FMUL = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [7:0] MUL_LAST = 8'(M);

  // a*t mod f: the bit shifted out of degree M-1 folds back to t^K + 1
  function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
    logic [M-1:0] r;
    r    = {a[M-2:0], 1'b0};
    r[0] = a[M-1];
    r[K] = r[K] ^ a[M-1];
    return r;
  endfunction

  // Interleave zeros, then fold the upper M-1 bits down twice
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
    logic [2*M-2:0] w;
    logic [M+K-2:0] r1;
    logic [M-1:0]   r2;
    w = '0;
    for (int i = 0; i < M; i++) begin
      w[2*i] = a[i];
    end
    r1             = '0;
    r1[M-1:0]      = w[M-1:0];
    r1[M-2:0]      = r1[M-2:0] ^ w[2*M-2:M];
    r1[M+K-2:K]    = r1[M+K-2:K] ^ w[2*M-2:M];
    r2             = r1[M-1:0];
    r2[K-2:0]      = r2[K-2:0] ^ r1[M+K-2:M];
    r2[2*K-2:K]    = r2[2*K-2:K] ^ r1[M+K-2:M];
    return r2;
  endfunction

  // Squaring count per addition-chain step
  function automatic logic [7:0] chain_j(input logic [3:0] step);
    logic [7:0] j;
    case (step)
      4'd0:    j = 8'd1;
      4'd1:    j = 8'd1;
      4'd2:    j = 8'd3;
      4'd3:    j = 8'd1;
      4'd4:    j = 8'd7;
      4'd5:    j = 8'd14;
      4'd6:    j = 8'd1;
      4'd7:    j = 8'd29;
      4'd8:    j = 8'd58;
      4'd9:    j = 8'd116;
      default: j = 8'd1;
    endcase
    return j;
  endfunction

  state_e       state_q, state_d;
  logic [M-1:0] t_q, t_d;
  logic [M-1:0] s_q, s_d;
  logic [M-1:0] xr_q, xr_d;
  logic [M-1:0] zr_q, zr_d;
  logic [M-1:0] acc_q, acc_d;
  logic [3:0]   step_q, step_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [M-1:0] x_out_q, x_out_d;
  logic [M-1:0] mul_acc_s;
  logic [3:0]   step_nx_s;
`ifdef ARS_P2A_ZCHK_EN
  logic         inf_q, inf_d;
`endif

  assign mul_acc_s = gf_xtime(acc_q) ^ (s_q[M-1] ? t_q : {M{1'b0}});
  assign step_nx_s = step_q + 4'd1;

  // Next-state and datapath updates; s doubles as the MSB-first shift operand of the multiplier
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    s_d     = s_q;
    xr_d    = xr_q;
    zr_d    = zr_q;
    acc_d   = acc_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_out_d = x_out_q;
`ifdef ARS_P2A_ZCHK_EN
    inf_d   = inf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (p2a.start_i) begin
          xr_d   = p2a.x_i;
          zr_d   = p2a.z_i;
          t_d    = p2a.z_i;
          s_d    = p2a.z_i;
          acc_d  = '0;
          step_d = 4'd0;
          cnt_d  = chain_j(4'd0);
          busy_d = 1'b1;
`ifdef ARS_P2A_ZCHK_EN
          inf_d  = (p2a.z_i == {M{1'b0}});
          if (p2a.z_i == {M{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SQR;
          end
`else
          state_d = S_SQR;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SQR: begin
        t_d = gf_sqr(t_q);
        if (cnt_q == 8'd1) begin
          state_d = S_MUL;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_MUL, S_FMUL: begin
        if (cnt_q == 8'd0) begin
          acc_d = '0;
          cnt_d = 8'd1;
        end else begin
          acc_d = mul_acc_s;
          s_d   = {s_q[M-2:0], 1'b0};
          if (cnt_q == MUL_LAST) begin
            if (state_q == S_FMUL) begin
              state_d = S_DONE;
            end else begin
              // b_(i+j) becomes the next squaring base; s picks up the next b_j
              step_d = step_nx_s;
              t_d    = mul_acc_s;
              s_d    = (chain_j(step_nx_s) == 8'd1) ? zr_q : mul_acc_s;
              cnt_d  = chain_j(step_nx_s);
              if (step_q == 4'd9) begin
                state_d = S_FSQ;
              end else begin
                state_d = S_SQR;
              end
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_FSQ: begin
        t_d     = gf_sqr(t_q);
        s_d     = xr_q;
        cnt_d   = 8'd0;
        state_d = S_FMUL;
      end
      S_DONE: begin
        x_out_d = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      s_q     <= '0;
      xr_q    <= '0;
      zr_q    <= '0;
      acc_q   <= '0;
      step_q  <= 4'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_out_q <= '0;
`ifdef ARS_P2A_ZCHK_EN
      inf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      s_q     <= s_d;
      xr_q    <= xr_d;
      zr_q    <= zr_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_out_q <= x_out_d;
`ifdef ARS_P2A_ZCHK_EN
      inf_q   <= inf_d;
`endif
    end
  end

  assign p2a.busy_o  = busy_q;
  assign p2a.done_o  = done_q;
  assign p2a.x_out_o = x_out_q;
`ifdef ARS_P2A_ZCHK_EN
  assign p2a.inf_o   = inf_q;
`else
  assign p2a.inf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ars_proj2aff.sv
// Directed bench for ars_proj2aff: latency, identity, inverse of t, random X*Z^-1, Z=0, ignored start, reset abort.
module tb_ars_proj2aff;

  localparam int LAT = 2807;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic busy_gap;

  always #5 clk = ~clk;

  ars_proj2aff_if bus ();

  ars_proj2aff dut (
    .clk (clk),
    .rst (rst),
    .p2a (bus)
  );

  function automatic logic [232:0] ref_mul(input logic [232:0] a, input logic [232:0] b);
    logic [464:0] p;
    p = '0;
    for (int i = 0; i < 233; i++) begin
      if (b[i]) p = p ^ ({232'b0, a} << i);
    end
    for (int d = 464; d >= 233; d--) begin
      if (p[d]) begin
        p[d]       = 1'b0;
        p[d - 233] = p[d - 233] ^ 1'b1;
        p[d - 159] = p[d - 159] ^ 1'b1;
      end
    end
    return p[232:0];
  endfunction

  function automatic logic [232:0] rand233();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
    return w[232:0];
  endfunction

  task automatic launch(input logic [232:0] xv, input logic [232:0] zv);
    @(negedge clk);
    bus.x_i     = xv;
    bus.z_i     = zv;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat      = 0;
    busy_gap = 1'b0;
    while (bus.done_o !== 1'b1 && lat < budget) begin
      if (bus.busy_o !== 1'b1) busy_gap = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input int lat, input int exp_lat,
                          input logic [232:0] exp_x);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (bus.x_out_o !== exp_x) begin
      n_err++;
      $display("FAIL %s x_out: got %h want %h", name, bus.x_out_o, exp_x);
    end
    n_vec++;
    if (busy_gap !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy: gap=%b at_done=%b want 0/0", name, busy_gap, bus.busy_o);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.x_i     = '0;
    bus.z_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.busy_o, bus.done_o, bus.inf_o} !== 3'b000 || bus.x_out_o !== 233'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b inf=%b x_out=%h want all 0",
               bus.busy_o, bus.done_o, bus.inf_o, bus.x_out_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int lat;
    launch(233'h1234, 233'd1);
    wait_done(3000, lat);
    check_op("z_one", lat, LAT, 233'h1234);
    n_vec++;
    if (bus.inf_o !== 1'b0) begin
      n_err++;
      $display("FAIL z_one inf: got %b want 0", bus.inf_o);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.done_o !== 1'b0 || bus.x_out_o !== 233'h1234) begin
      n_err++;
      $display("FAIL done_pulse: done=%b x_out=%h want 0 and held 1234", bus.done_o, bus.x_out_o);
    end
  endtask

  task automatic test_inv_t();
    int lat;
    logic [232:0] e;
    e      = '0;
    e[232] = 1'b1;
    e[73]  = 1'b1;
    launch(233'd1, 233'd2);
    wait_done(3000, lat);
    check_op("inv_t", lat, LAT, e);
  endtask

  task automatic test_random();
    int lat;
    logic [232:0] xv, zv;
    for (int i = 0; i < 2; i++) begin
      zv = rand233() | 233'd1;
      launch(zv, zv);
      wait_done(3000, lat);
      check_op("x_eq_z", lat, LAT, 233'd1);
    end
    for (int i = 0; i < 4; i++) begin
      xv = rand233();
      zv = rand233() | 233'd4;
      launch(xv, zv);
      wait_done(3000, lat);
      n_vec++;
      if (lat !== LAT || ref_mul(bus.x_out_o, zv) !== xv) begin
        n_err++;
        $display("FAIL rand_div: lat=%0d x_out=%h (x_out*Z=%h) want lat %0d X=%h",
                 lat, bus.x_out_o, ref_mul(bus.x_out_o, zv), LAT, xv);
      end
    end
  endtask

  task automatic test_zero();
    int lat;
    launch(233'd5, 233'd0);
    wait_done(3000, lat);
`ifdef ARS_P2A_ZCHK_EN
    check_op("z_zero", lat, 1, 233'd0);
    n_vec++;
    if (bus.inf_o !== 1'b1) begin
      n_err++;
      $display("FAIL z_zero inf: got %b want 1", bus.inf_o);
    end
`else
    check_op("z_zero", lat, LAT, 233'd0);
    n_vec++;
    if (bus.inf_o !== 1'b0) begin
      n_err++;
      $display("FAIL z_zero inf: got %b want 0", bus.inf_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    int early;
    logic [232:0] xv, zv;
    early = 0;
    launch(233'habcdef, 233'd1);
    repeat (100) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1) early++;
    end
    bus.x_i     = 233'd7;
    bus.z_i     = 233'd3;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_done(3000, lat);
    check_op("ignored_start", lat + 101, LAT, 233'habcdef);
    n_vec++;
    if (early !== 0 || bus.inf_o !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_start extra: early_done=%0d inf=%b want 0/0", early, bus.inf_o);
    end
    xv          = rand233();
    zv          = rand233() | 233'd2;
    bus.x_i     = xv;
    bus.z_i     = zv;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_done(3000, lat);
    n_vec++;
    if (lat !== LAT || ref_mul(bus.x_out_o, zv) !== xv) begin
      n_err++;
      $display("FAIL back_to_back: lat=%0d x_out=%h want lat %0d and x_out*Z=%h",
               lat, bus.x_out_o, LAT, xv);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    logic [232:0] xv, zv;
    pulses = 0;
    launch(233'h55, 233'd1);
    repeat (1500) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.x_out_o !== 233'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b x_out=%h want 0/0/0",
               bus.busy_o, bus.done_o, bus.x_out_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (1400) begin
      @(posedge clk);
      #1;
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0 || bus.x_out_o !== 233'd0) begin
      n_err++;
      $display("FAIL reset_mid quiet: active_cycles=%0d x_out=%h want 0/0", pulses, bus.x_out_o);
    end
    xv = rand233();
    zv = rand233() | 233'd8;
    launch(xv, zv);
    wait_done(3000, lat);
    n_vec++;
    if (lat !== LAT || ref_mul(bus.x_out_o, zv) !== xv) begin
      n_err++;
      $display("FAIL reset_mid restart: lat=%0d x_out=%h want lat %0d and x_out*Z=%h",
               lat, bus.x_out_o, LAT, xv);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_inv_t();
    test_random();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
